// File: rtl/qspi_flash_reader.sv
// qspi_flash_reader: AXI4-Lite master that reads a block of 32-bit words from the
// QSPI wrapper register port and streams them out on a valid/ready interface.
// Optional feature macro QSPI_FLASH_READER_CSUM_EN adds a running 32-bit word checksum.
module qspi_flash_reader #(
  parameter logic [31:0] ADDR_REG     = 32'h00,
  parameter logic [31:0] CMD_REG      = 32'h04,
  parameter logic [31:0] STAT_REG     = 32'h08,
  parameter logic [31:0] DATA_REG     = 32'h0C,
  parameter logic [31:0] RD_CMD       = 32'h0000_006B,
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned POLL_TIMEOUT = 4096
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic             start,
  input  logic [23:0]      flash_addr,
  input  logic [CNT_W-1:0] word_cnt,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [31:0]      m_bus_awaddr,
  output logic [2:0]       m_bus_awprot,
  output logic             m_bus_awvalid,
  input  logic             m_bus_awready,
  output logic [31:0]      m_bus_wdata,
  output logic [3:0]       m_bus_wstrb,
  output logic             m_bus_wvalid,
  input  logic             m_bus_wready,
  input  logic [1:0]       m_bus_bresp,
  input  logic             m_bus_bvalid,
  output logic             m_bus_bready,
  output logic [31:0]      m_bus_araddr,
  output logic [2:0]       m_bus_arprot,
  output logic             m_bus_arvalid,
  input  logic             m_bus_arready,
  input  logic [31:0]      m_bus_rdata,
  input  logic [1:0]       m_bus_rresp,
  input  logic             m_bus_rvalid,
  output logic             m_bus_rready,
  output logic [31:0]      out_data,
  output logic             out_valid,
  input  logic             out_ready
`ifdef QSPI_FLASH_READER_CSUM_EN
  ,
  output logic [31:0]      csum
`endif
);

  localparam int unsigned POLL_W = $clog2(POLL_TIMEOUT + 1);

  typedef enum logic [3:0] {
    IDLE, WR_ADDR, WR_CMD, POLL_AR, POLL_R, DATA_AR, DATA_R, PUSH, FIN
  } state_t;

  state_t            state, state_n;
  logic [23:0]       addr, addr_n, addr_inc;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [POLL_W-1:0] poll_cnt, poll_cnt_n;
  logic              busy_n, done_n, error_n, fail;
  logic [31:0]       awaddr_n, wdata_n, araddr_n, out_data_n;
  logic              awvalid_n, wvalid_n, bready_n, arvalid_n, rready_n, out_valid_n;
`ifdef QSPI_FLASH_READER_CSUM_EN
  logic [31:0]       csum_n;
`endif

  assign m_bus_awprot = 3'b000;
  assign m_bus_arprot = 3'b000;
  assign m_bus_wstrb  = 4'hF;
  assign addr_inc     = addr + 24'd4;

  // Register every state bit and bus/stream output.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state         <= IDLE;
      addr          <= '0;
      cnt           <= '0;
      poll_cnt      <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      m_bus_awaddr  <= '0;
      m_bus_awvalid <= 1'b0;
      m_bus_wdata   <= '0;
      m_bus_wvalid  <= 1'b0;
      m_bus_bready  <= 1'b0;
      m_bus_araddr  <= '0;
      m_bus_arvalid <= 1'b0;
      m_bus_rready  <= 1'b0;
      out_data      <= '0;
      out_valid     <= 1'b0;
`ifdef QSPI_FLASH_READER_CSUM_EN
      csum          <= '0;
`endif
    end else begin
      state         <= state_n;
      addr          <= addr_n;
      cnt           <= cnt_n;
      poll_cnt      <= poll_cnt_n;
      busy          <= busy_n;
      done          <= done_n;
      error         <= error_n;
      m_bus_awaddr  <= awaddr_n;
      m_bus_awvalid <= awvalid_n;
      m_bus_wdata   <= wdata_n;
      m_bus_wvalid  <= wvalid_n;
      m_bus_bready  <= bready_n;
      m_bus_araddr  <= araddr_n;
      m_bus_arvalid <= arvalid_n;
      m_bus_rready  <= rready_n;
      out_data      <= out_data_n;
      out_valid     <= out_valid_n;
`ifdef QSPI_FLASH_READER_CSUM_EN
      csum          <= csum_n;
`endif
    end
  end

  // Sequencer: per word write address, write command, poll status, read data, push.
  always_comb begin
    state_n     = state;
    addr_n      = addr;
    cnt_n       = cnt;
    poll_cnt_n  = poll_cnt;
    busy_n      = busy;
    done_n      = 1'b0;
    error_n     = 1'b0;
    fail        = 1'b0;
    awaddr_n    = m_bus_awaddr;
    awvalid_n   = m_bus_awvalid;
    wdata_n     = m_bus_wdata;
    wvalid_n    = m_bus_wvalid;
    bready_n    = m_bus_bready;
    araddr_n    = m_bus_araddr;
    arvalid_n   = m_bus_arvalid;
    rready_n    = m_bus_rready;
    out_data_n  = out_data;
    out_valid_n = out_valid;
`ifdef QSPI_FLASH_READER_CSUM_EN
    csum_n      = csum;
`endif

    case (state)
      IDLE: begin
        if (start) begin
`ifdef QSPI_FLASH_READER_CSUM_EN
          csum_n = '0;
`endif
          if (word_cnt == '0) begin
            done_n = 1'b1;
          end else begin
            addr_n     = flash_addr;
            cnt_n      = word_cnt;
            poll_cnt_n = '0;
            busy_n     = 1'b1;
            state_n    = WR_ADDR;
            awvalid_n  = 1'b1;
            wvalid_n   = 1'b1;
            awaddr_n   = ADDR_REG;
            wdata_n    = {8'h00, flash_addr};
          end
        end
      end

      WR_ADDR, WR_CMD: begin
        if (m_bus_awvalid && m_bus_awready) awvalid_n = 1'b0;
        if (m_bus_wvalid && m_bus_wready)   wvalid_n  = 1'b0;
        if (m_bus_bready) begin
          if (m_bus_bvalid) begin
            bready_n = 1'b0;
            if (m_bus_bresp != 2'b00) begin
              fail = 1'b1;
            end else if (state == WR_ADDR) begin
              state_n   = WR_CMD;
              awvalid_n = 1'b1;
              wvalid_n  = 1'b1;
              awaddr_n  = CMD_REG;
              wdata_n   = RD_CMD;
            end else begin
              state_n   = POLL_AR;
              arvalid_n = 1'b1;
              araddr_n  = STAT_REG;
            end
          end
        end else if ((!m_bus_awvalid || m_bus_awready) && (!m_bus_wvalid || m_bus_wready)) begin
          bready_n = 1'b1;
        end
      end

      POLL_AR, DATA_AR: begin
        if (m_bus_arready) begin
          arvalid_n = 1'b0;
          rready_n  = 1'b1;
          state_n   = (state == POLL_AR) ? POLL_R : DATA_R;
        end
      end

      POLL_R: begin
        if (m_bus_rvalid) begin
          rready_n = 1'b0;
          if (m_bus_rresp != 2'b00) begin
            fail = 1'b1;
          end else if (m_bus_rdata[0]) begin
            if (poll_cnt == POLL_W'(POLL_TIMEOUT - 1)) begin
              fail = 1'b1;
            end else begin
              poll_cnt_n = poll_cnt + POLL_W'(1);
              state_n    = POLL_AR;
              arvalid_n  = 1'b1;
              araddr_n   = STAT_REG;
            end
          end else begin
            poll_cnt_n = '0;
            state_n    = DATA_AR;
            arvalid_n  = 1'b1;
            araddr_n   = DATA_REG;
          end
        end
      end

      DATA_R: begin
        if (m_bus_rvalid) begin
          rready_n = 1'b0;
          if (m_bus_rresp != 2'b00) begin
            fail = 1'b1;
          end else begin
            out_data_n  = m_bus_rdata;
            out_valid_n = 1'b1;
            state_n     = PUSH;
          end
        end
      end

      PUSH: begin
        if (out_ready) begin
          out_valid_n = 1'b0;
          addr_n      = addr_inc;
          cnt_n       = cnt - CNT_W'(1);
`ifdef QSPI_FLASH_READER_CSUM_EN
          csum_n      = csum + out_data;
`endif
          if (cnt == CNT_W'(1)) begin
            state_n = FIN;
          end else begin
            state_n   = WR_ADDR;
            awvalid_n = 1'b1;
            wvalid_n  = 1'b1;
            awaddr_n  = ADDR_REG;
            wdata_n   = {8'h00, addr_inc};
          end
        end
      end

      FIN: begin
        done_n  = 1'b1;
        busy_n  = 1'b0;
        state_n = IDLE;
      end

      default: state_n = IDLE;
    endcase

    // Abort after the failing handshake has completed.
    if (fail) begin
      error_n    = 1'b1;
      busy_n     = 1'b0;
      poll_cnt_n = '0;
      state_n    = IDLE;
    end
  end

endmodule

// File: tb/tb_qspi_flash_reader.sv
// Bench for qspi_flash_reader: AXI4-Lite slave model of the QSPI wrapper, a
// per-run expectation model, and a per-cycle stream monitor.
module tb_qspi_flash_reader;

  logic        aclk = 1'b0;
  logic        areset, start, out_ready;
  logic [23:0] flash_addr;
  logic [15:0] word_cnt;
  logic        busy, done, error, out_valid;
  logic [31:0] out_data;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  bresp, rresp;
`ifdef QSPI_FLASH_READER_CSUM_EN
  logic [31:0] csum;
`endif

  always #5 aclk = ~aclk;

  qspi_flash_reader dut (
    .aclk(aclk), .areset(areset), .start(start), .flash_addr(flash_addr), .word_cnt(word_cnt),
    .busy(busy), .done(done), .error(error),
    .m_bus_awaddr(awaddr), .m_bus_awprot(awprot), .m_bus_awvalid(awvalid), .m_bus_awready(awready),
    .m_bus_wdata(wdata), .m_bus_wstrb(wstrb), .m_bus_wvalid(wvalid), .m_bus_wready(wready),
    .m_bus_bresp(bresp), .m_bus_bvalid(bvalid), .m_bus_bready(bready),
    .m_bus_araddr(araddr), .m_bus_arprot(arprot), .m_bus_arvalid(arvalid), .m_bus_arready(arready),
    .m_bus_rdata(rdata), .m_bus_rresp(rresp), .m_bus_rvalid(rvalid), .m_bus_rready(rready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
`ifdef QSPI_FLASH_READER_CSUM_EN
    , .csum(csum)
`endif
  );

  // ---------------- slave model of the wrapper register port ----------------
  int          busy_polls_cfg = 0;   // status reads per word that report busy
  int          fail_wr_abs = -1;     // absolute write index answered with SLVERR
  int          wr_total = 0, aw_hs_cnt = 0, ar_hs_cnt = 0, stat_reads = 0;
  logic [31:0] act_wr_addr[$], act_wr_data[$];

  initial begin
    logic        rst_s, hs_aw, hs_w, hs_b, hs_ar, hs_r, aw_got, w_got;
    logic [31:0] aw_a, w_d, ar_a, wa, wd;
    logic [23:0] cur_addr;
    int          stat_word;
    awready = 1'b1; wready = 1'b1; arready = 1'b1;
    bvalid = 1'b0; bresp = 2'b00; rvalid = 1'b0; rresp = 2'b00; rdata = '0;
    aw_got = 1'b0; w_got = 1'b0; wa = '0; wd = '0; cur_addr = '0; stat_word = 0;
    forever begin
      @(negedge aclk);
      rst_s = areset;
      hs_aw = awvalid && awready; hs_w = wvalid && wready; hs_b = bvalid && bready;
      hs_ar = arvalid && arready; hs_r = rvalid && rready;
      aw_a = awaddr; w_d = wdata; ar_a = araddr;
      @(posedge aclk);
      #1;
      if (rst_s) begin
        bvalid = 1'b0; rvalid = 1'b0; wready = 1'b1;
        aw_got = 1'b0; w_got = 1'b0; stat_word = 0;
      end else begin
        if (hs_aw) begin aw_got = 1'b1; wa = aw_a; aw_hs_cnt++; end
        if (hs_w)  begin w_got = 1'b1; wd = w_d; end
        if (hs_b) begin
          bvalid = 1'b0;
        end else if (aw_got && w_got && !bvalid) begin
          act_wr_addr.push_back(wa);
          act_wr_data.push_back(wd);
          if (wa == 32'h0) begin cur_addr = wd[23:0]; stat_word = 0; end
          bresp = (wr_total == fail_wr_abs) ? 2'b10 : 2'b00;
          wr_total++;
          bvalid = 1'b1; aw_got = 1'b0; w_got = 1'b0;
        end
        if (hs_r) rvalid = 1'b0;
        if (hs_ar) begin
          ar_hs_cnt++;
          rresp = 2'b00;
          if (ar_a == 32'h8) begin
            stat_reads++;
            rdata = (stat_word < busy_polls_cfg) ? 32'h1 : 32'h0;
            stat_word++;
          end else begin
            rdata = {8'hA0, cur_addr};
          end
          rvalid = 1'b1;
        end
        wready = ~wready;
      end
    end
  end

  // ---------------- expectation model and checking ----------------
  int          checks = 0, errors = 0;
  logic [31:0] exp_wr_addr[$], exp_wr_data[$], exp_words[$];
  logic [31:0] exp_sum;
  int          exp_stat, exp_ar, exp_done, exp_err;
  int          done_cnt, err_cnt, out_hs_cnt, ov_cycles;
  int          wr_base, aw_base, ar_base, stat_base;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Expected traffic from the read-block rules: two writes, polls, one data read per word.
  task automatic build_model(input logic [23:0] a0, input int cnt, input int bpolls, input int fail);
    logic [23:0] a;
    bit          stop;
    exp_wr_addr.delete(); exp_wr_data.delete(); exp_words.delete();
    exp_stat = 0; exp_ar = 0; exp_done = 0; exp_err = 0; exp_sum = '0;
    a = a0; stop = 1'b0;
    for (int i = 0; i < cnt; i++) begin
      if (!stop) begin
        exp_wr_addr.push_back(32'h0); exp_wr_data.push_back({8'h00, a});
        if (fail == 2 * i) begin
          exp_err = 1; stop = 1'b1;
        end else begin
          exp_wr_addr.push_back(32'h4); exp_wr_data.push_back(32'h6B);
          if (fail == 2 * i + 1) begin
            exp_err = 1; stop = 1'b1;
          end else if (bpolls >= 4096) begin
            exp_stat += 4096; exp_ar += 4096; exp_err = 1; stop = 1'b1;
          end else begin
            exp_stat += bpolls + 1;
            exp_ar   += bpolls + 2;
            exp_words.push_back({8'hA0, a});
            exp_sum  += {8'hA0, a};
            a = a + 24'd4;
          end
        end
      end
    end
    if (!stop) exp_done = 1;
  endtask

  task automatic start_run(input logic [23:0] a0, input int cnt, input int bpolls, input int fail);
    build_model(a0, cnt, bpolls, fail);
    busy_polls_cfg = bpolls;
    fail_wr_abs = (fail < 0) ? -1 : wr_total + fail;
    wr_base = act_wr_addr.size(); aw_base = aw_hs_cnt; ar_base = ar_hs_cnt; stat_base = stat_reads;
    done_cnt = 0; err_cnt = 0; out_hs_cnt = 0; ov_cycles = 0;
    flash_addr = a0; word_cnt = 16'(cnt);
  endtask

  task automatic pulse_start();
    @(posedge aclk); #1;
    start = 1'b1;
    @(posedge aclk); #1;
    start = 1'b0;
  endtask

  task automatic wait_end(input int budget);
    int n = 0;
    while (done_cnt == 0 && err_cnt == 0 && n < budget) begin
      @(posedge aclk); #1;
      n++;
    end
    chk("end_timeout", 32'(n >= budget), 32'd0);
    repeat (4) @(posedge aclk);
    #1;
  endtask

  task automatic end_checks(input string tag);
    int nw;
    nw = act_wr_addr.size() - wr_base;
    chk({tag, "_done_cnt"}, 32'(done_cnt), 32'(exp_done));
    chk({tag, "_err_cnt"}, 32'(err_cnt), 32'(exp_err));
    chk({tag, "_busy_end"}, 32'(busy), 32'd0);
    chk({tag, "_num_writes"}, 32'(nw), 32'(exp_wr_addr.size()));
    for (int i = 0; i < exp_wr_addr.size() && i < nw; i++) begin
      chk({tag, "_wr_addr"}, act_wr_addr[wr_base + i], exp_wr_addr[i]);
      chk({tag, "_wr_data"}, act_wr_data[wr_base + i], exp_wr_data[i]);
    end
    chk({tag, "_aw_count"}, 32'(aw_hs_cnt - aw_base), 32'(exp_wr_addr.size()));
    chk({tag, "_ar_count"}, 32'(ar_hs_cnt - ar_base), 32'(exp_ar));
    chk({tag, "_stat_reads"}, 32'(stat_reads - stat_base), 32'(exp_stat));
    chk({tag, "_words_out"}, 32'(out_hs_cnt), 32'(exp_words.size()));
    if (exp_words.size() == 0) chk({tag, "_no_out_valid"}, 32'(ov_cycles), 32'd0);
  endtask

  // Per-cycle stream monitor: word order/values, hold stability, pulse counting.
  task automatic monitor();
    bit          hold = 1'b0;
    logic [31:0] hold_data = '0;
    forever begin
      @(negedge aclk);
      if (areset) begin
        hold = 1'b0;
      end else begin
        if (hold) begin
          chk("hold_valid", 32'(out_valid), 32'd1);
          chk("hold_data", out_data, hold_data);
        end
        if (out_valid) ov_cycles++;
        if (out_valid && out_ready) begin
          if (out_hs_cnt < exp_words.size()) chk("stream_word", out_data, exp_words[out_hs_cnt]);
          else chk("stream_extra_word", out_data, 32'hDEAD_BEEF ^ out_data ^ 32'h1);
          out_hs_cnt++;
        end
        if (done) begin
          done_cnt++;
`ifdef QSPI_FLASH_READER_CSUM_EN
          chk("csum_at_done", csum, exp_sum);
`endif
        end
        if (error) err_cnt++;
        hold = out_valid && !out_ready;
        hold_data = out_data;
      end
    end
  endtask

  initial begin
    areset = 1'b1; start = 1'b0; out_ready = 1'b1; flash_addr = '0; word_cnt = '0;
    done_cnt = 0; err_cnt = 0; out_hs_cnt = 0; ov_cycles = 0;
    fork monitor(); join_none

    // Reset values
    repeat (3) @(posedge aclk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_valids", {28'd0, awvalid, wvalid, arvalid, 1'b0}, 32'd0);
    chk("rst_readies", {30'd0, bready, rready}, 32'd0);
    chk("prot_strb", {21'd0, awprot, arprot, wstrb, 1'b0}, 32'h1E);
`ifdef QSPI_FLASH_READER_CSUM_EN
    chk("rst_csum", csum, 32'd0);
`endif
    areset = 1'b0;

    // Three words from 0x001000, status idle at first poll
    start_run(24'h001000, 3, 0, -1);
    chk("model_word0", exp_words[0], 32'hA000_1000);
    chk("model_wr2", exp_wr_data[2], 32'h0000_1004);
    chk("model_sum", exp_sum, 32'hE000_300C);
    pulse_start();
    chk("busy_after_start", 32'(busy), 32'd1);
    wait_end(2000);
    end_checks("blk3");

    // Five busy polls before idle
    start_run(24'h000200, 1, 5, -1);
    pulse_start();
    wait_end(2000);
    end_checks("poll5");
    chk("poll5_stat_literal", 32'(stat_reads - stat_base), 32'd6);

    // Status stuck busy -> timeout
    start_run(24'h002000, 2, 1000000, -1);
    pulse_start();
    wait_end(20000);
    end_checks("stuck");
    chk("stuck_stat_literal", 32'(stat_reads - stat_base), 32'd4096);

    // SLVERR on the command write
    start_run(24'h003000, 2, 0, 1);
    pulse_start();
    wait_end(2000);
    end_checks("bresp");

    // Backpressure in PUSH, start pulses ignored, address wraps at 24 bits
    out_ready = 1'b0;
    start_run(24'hFFFFFC, 2, 0, -1);
    chk("model_wrap_word", exp_words[1], 32'hA000_0000);
    pulse_start();
    begin
      int n = 0;
      int aw0;
      while (!out_valid && n < 500) begin @(posedge aclk); #1; n++; end
      chk("push_reached", 32'(out_valid), 32'd1);
      aw0 = aw_hs_cnt;
      for (int i = 0; i < 20; i++) begin
        @(posedge aclk); #1;
        start = (i == 3 || i == 10);
        flash_addr = 24'h123400; word_cnt = 16'd5;
      end
      start = 1'b0;
      chk("hold_no_aw", 32'(aw_hs_cnt - aw0), 32'd0);
      chk("hold_busy", 32'(busy), 32'd1);
    end
    out_ready = 1'b1;
    wait_end(2000);
    end_checks("hold");

    // Zero word count: done the cycle after start, no bus traffic
    start_run(24'h005000, 0, 0, -1);
    @(posedge aclk); #1;
    start = 1'b1;
    @(posedge aclk); #1;
    start = 1'b0;
    chk("cnt0_done_next", 32'(done), 32'd1);
    chk("cnt0_busy", 32'(busy), 32'd0);
    @(posedge aclk); #1;
    chk("cnt0_done_once", 32'(done), 32'd0);
    repeat (5) @(posedge aclk);
    #1;
    end_checks("cnt0");

    // Reset in the middle of a status read
    start_run(24'h004000, 1, 1000000, -1);
    pulse_start();
    begin
      int n = 0;
      while (!(rready && (stat_reads - stat_base) >= 2) && n < 500) begin @(posedge aclk); #1; n++; end
      chk("in_poll_r", 32'(rready), 32'd1);
    end
    areset = 1'b1;
    @(posedge aclk); #1;
    areset = 1'b0;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_error", 32'(error), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_out", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_out_data", out_data, 32'd0);
    chk("mid_rst_bus", {27'd0, awvalid, wvalid, bready, arvalid, rready}, 32'd0);
    repeat (3) @(posedge aclk);

    // Recovery after reset
    start_run(24'h000100, 1, 2, -1);
    pulse_start();
    wait_end(2000);
    end_checks("recover");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
